// File: rtl/divider_n.sv
// -----------------------------------------------------------------------------
// divider_n
//
// Sequential restoring divider. It handles both signed (two's-complement,
// truncating) and unsigned division, using one shift-subtract step per clock.
//
// Operands are converted to magnitudes when the request is accepted. The core
// then runs WIDTH restoring iterations on a (2*WIDTH+1)-bit remainder/quotient
// register. A final cycle applies sign correction and registers the result.
// A zero divisor skips the iteration phase. In that case the result is
// Hi = A, Lo = all ones and div0 = 1.
//
// Ports
//   clock      : single clock, all state changes on the rising edge
//   reset_n    : asynchronous active-low reset
//   start      : request a division (only honoured in IDLE)
//   is_signed  : 1 = two's-complement division, 0 = unsigned (sampled with start)
//   A, B       : dividend / divisor (sampled with start)
//   Hi, Lo     : registered remainder / quotient
//   busy       : division in progress
//   done       : one-cycle pulse, Hi/Lo/div0 valid
//   div0       : registered divide-by-zero flag of the last accepted operation
// -----------------------------------------------------------------------------
module divider_n #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH:0]   rq_q, rq_d;          // {remainder, quotient/dividend}
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic               sign_a_q, sign_a_d;  // dividend was negative (signed op)
  logic               qneg_q, qneg_d;      // quotient must be negated
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div0_q, div0_d;

  // Operand magnitudes at acceptance.
  logic [WIDTH-1:0]   a_mag, b_mag;

  // One restoring iteration.
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     upper;
  logic [WIDTH:0]     diff;
  logic               fits;

  // Unsigned results held in rq_q when the iteration phase is complete.
  logic [WIDTH-1:0]   q_mag, r_mag;

  always_comb begin
    a_mag = (is_signed && A[WIDTH-1]) ? -A : A;
    b_mag = (is_signed && B[WIDTH-1]) ? -B : B;

    shifted = rq_q << 1;
    upper   = shifted[2*WIDTH:WIDTH];
    diff    = upper - {1'b0, b_mag_q};
    // The remainder before the shift is below the divisor, so upper < 2*divisor.
    // If upper[WIDTH] is set, the divisor always fits. Otherwise both operands
    // fit in WIDTH bits, and diff[WIDTH] is the borrow.
    fits    = upper[WIDTH] | ~diff[WIDTH];

    q_mag = rq_q[WIDTH-1:0];
    r_mag = rq_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned;
    // without this an incomplete case/if would infer a latch.
    state_d  = state_q;
    rq_d     = rq_q;
    b_mag_d  = b_mag_q;
    sign_a_d = sign_a_q;
    qneg_d   = qneg_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div0_d   = div0_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_a_d = is_signed & A[WIDTH-1];
          qneg_d   = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          b_mag_d  = b_mag;
          rq_d     = {{(WIDTH+1){1'b0}}, a_mag};
          cnt_d    = '0;
          busy_d   = 1'b1;
          if (B == '0) begin
            div0_d  = 1'b1;
            state_d = FINISH;
          end else begin
            div0_d  = 1'b0;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        rq_d  = fits ? {diff, shifted[WIDTH-1:1], 1'b1} : shifted;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        if (div0_q) begin
          // rq_q still holds the dividend magnitude, so re-signing it
          // recovers A exactly as it was latched.
          hi_d = sign_a_q ? -q_mag : q_mag;
          lo_d = '1;
        end else begin
          hi_d = sign_a_q ? -r_mag : r_mag;
          lo_d = qneg_q   ? -q_mag : q_mag;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rq_q     <= '0;
      b_mag_q  <= '0;
      sign_a_q <= 1'b0;
      qneg_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rq_q     <= rq_d;
      b_mag_q  <= b_mag_d;
      sign_a_q <= sign_a_d;
      qneg_q   <= qneg_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_divider_n.sv
// -----------------------------------------------------------------------------
// tb_divider_n
//
// Self-checking bench for divider_n. It drives one 32-bit and one 8-bit
// instance from a shared clock and reset. Expected results come from a
// behavioural model that uses the simulator's own integer division on
// sign-extended 64-bit values.
// -----------------------------------------------------------------------------
module tb_divider_n;

  logic        clk;
  logic        reset_n;

  logic        s32_start, s32_sgn;
  logic [31:0] s32_a, s32_b, hi32, lo32;
  logic        busy32, done32, div0_32;

  logic        s8_start, s8_sgn;
  logic [7:0]  s8_a, s8_b, hi8, lo8;
  logic        busy8, done8, div0_8;

  int pass_cnt  = 0;
  int total_cnt = 0;

  divider_n #(.WIDTH(32)) dut32 (
    .clock(clk), .reset_n(reset_n), .start(s32_start), .is_signed(s32_sgn),
    .A(s32_a), .B(s32_b), .Hi(hi32), .Lo(lo32),
    .busy(busy32), .done(done32), .div0(div0_32)
  );

  divider_n #(.WIDTH(8)) dut8 (
    .clock(clk), .reset_n(reset_n), .start(s8_start), .is_signed(s8_sgn),
    .A(s8_a), .B(s8_b), .Hi(hi8), .Lo(lo8),
    .busy(busy8), .done(done8), .div0(div0_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating division on sign-extended values.
  function automatic void model(input int w, input logic sgn,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] hi, output logic [63:0] lo,
                                output logic d0);
    logic [63:0] mask;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    if (b == 64'd0) begin
      hi = a;
      lo = mask;
      d0 = 1'b1;
    end else if (sgn) begin
      sa = a[w-1] ? longint'(a | ~mask) : longint'(a);
      sb = b[w-1] ? longint'(b | ~mask) : longint'(b);
      lo = 64'(sa / sb) & mask;
      hi = 64'(sa % sb) & mask;
      d0 = 1'b0;
    end else begin
      lo = a / b;
      hi = a % b;
      d0 = 1'b0;
    end
  endfunction

  task automatic drive(input logic w8, input logic st, input logic sg,
                       input logic [63:0] a, input logic [63:0] b);
    if (w8) begin
      s8_start = st; s8_sgn = sg; s8_a = a[7:0]; s8_b = b[7:0];
    end else begin
      s32_start = st; s32_sgn = sg; s32_a = a[31:0]; s32_b = b[31:0];
    end
  endtask

  function automatic void sample(input logic w8, output logic [63:0] hi,
                                 output logic [63:0] lo, output logic bsy,
                                 output logic dn, output logic d0);
    if (w8) begin
      hi = {56'd0, hi8}; lo = {56'd0, lo8}; bsy = busy8; dn = done8; d0 = div0_8;
    end else begin
      hi = {32'd0, hi32}; lo = {32'd0, lo32}; bsy = busy32; dn = done32; d0 = div0_32;
    end
  endfunction

  // Issue one operation and check it. Call this away from a clock edge.
  // The inputs are scrambled after acceptance to show that they are latched.
  task automatic run_op(input logic w8, input logic sgn, input logic [63:0] a_in,
                        input logic [63:0] b_in, input string name,
                        output logic [63:0] o_hi, output logic [63:0] o_lo,
                        output logic o_d0);
    int          w, lat, exp_lat;
    logic [63:0] mask, a, b, e_hi, e_lo, hi, lo, hi2, lo2;
    logic        e_d0, bsy, dn, d0;
    w    = w8 ? 8 : 32;
    mask = (64'd1 << w) - 64'd1;
    a    = a_in & mask;
    b    = b_in & mask;
    exp_lat = (b == 64'd0) ? 1 : w + 1;
    model(w, sgn, a, b, e_hi, e_lo, e_d0);

    drive(w8, 1'b1, sgn, a, b);
    @(posedge clk); #1;
    sample(w8, hi, lo, bsy, dn, d0);
    total_cnt++;
    if (bsy !== 1'b1 || dn !== 1'b0)
      $display("FAIL %s accept: busy=%b done=%b, required busy=1 done=0", name, bsy, dn);
    else pass_cnt++;

    drive(w8, 1'b0, 1'(bit'($urandom_range(1))), {$urandom, $urandom}, {$urandom, $urandom});
    lat = 0;
    dn  = 1'b0;
    while (lat < 200 && dn !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
      sample(w8, hi, lo, bsy, dn, d0);
    end
    total_cnt++;
    if (lat !== exp_lat)
      $display("FAIL %s latency: got %0d edges, required %0d", name, lat, exp_lat);
    else pass_cnt++;

    total_cnt++;
    if (hi !== e_hi || lo !== e_lo || d0 !== e_d0 || bsy !== 1'b0)
      $display("FAIL %s result (w=%0d s=%b a=%h b=%h): hi=%h lo=%h div0=%b busy=%b, required hi=%h lo=%h div0=%b busy=0",
               name, w, sgn, a, b, hi, lo, d0, bsy, e_hi, e_lo, e_d0);
    else pass_cnt++;

    // The done pulse is one cycle long, and the outputs hold afterwards.
    @(posedge clk); #1;
    sample(w8, hi2, lo2, bsy, dn, d0);
    total_cnt++;
    if (dn !== 1'b0 || bsy !== 1'b0 || hi2 !== e_hi || lo2 !== e_lo || d0 !== e_d0)
      $display("FAIL %s hold: done=%b busy=%b hi=%h lo=%h div0=%b, required done=0 busy=0 hi=%h lo=%h div0=%b",
               name, dn, bsy, hi2, lo2, d0, e_hi, e_lo, e_d0);
    else pass_cnt++;

    o_hi = hi; o_lo = lo; o_d0 = d0;
  endtask

  // Reset values, followed by a start on the very first edge after release.
  task automatic test_reset;
    logic [63:0] hi, lo;
    logic        d0;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    #23;
    total_cnt++;
    if ({hi32, lo32, busy32, done32, div0_32} !== 67'd0 || {hi8, lo8, busy8, done8, div0_8} !== 19'd0)
      $display("FAIL reset_values: hi32=%h lo32=%h b/d/z=%b%b%b hi8=%h lo8=%h b/d/z=%b%b%b, required all 0",
               hi32, lo32, busy32, done32, div0_32, hi8, lo8, busy8, done8, div0_8);
    else pass_cnt++;
    reset_n = 1'b1;
    run_op(1'b0, 1'b1, 64'd7, 64'd2, "first_edge_7div2", hi, lo, d0);
    total_cnt++;
    if (lo !== 64'h3 || hi !== 64'h1 || d0 !== 1'b0)
      $display("FAIL spec_7div2: lo=%h hi=%h div0=%b, required lo=3 hi=1 div0=0", lo, hi, d0);
    else pass_cnt++;
  endtask

  task automatic test_signs;
    logic [63:0] hi, lo;
    logic        d0;
    run_op(1'b0, 1'b1, 64'hFFFFFFF9, 64'd2, "neg7div2_signed", hi, lo, d0);
    total_cnt++;
    if (lo !== 64'hFFFFFFFD || hi !== 64'hFFFFFFFF)
      $display("FAIL spec_neg7_signed: lo=%h hi=%h, required lo=fffffffd hi=ffffffff", lo, hi);
    else pass_cnt++;
    run_op(1'b0, 1'b0, 64'hFFFFFFF9, 64'd2, "neg7div2_unsigned", hi, lo, d0);
    total_cnt++;
    if (lo !== 64'h7FFFFFFC || hi !== 64'h1)
      $display("FAIL spec_neg7_unsigned: lo=%h hi=%h, required lo=7ffffffc hi=1", lo, hi);
    else pass_cnt++;
  endtask

  task automatic test_overflow;
    logic [63:0] hi, lo;
    logic        d0;
    run_op(1'b0, 1'b1, 64'h80000000, 64'hFFFFFFFF, "overflow", hi, lo, d0);
    total_cnt++;
    if (lo !== 64'h80000000 || hi !== 64'h0 || d0 !== 1'b0)
      $display("FAIL spec_overflow: lo=%h hi=%h div0=%b, required lo=80000000 hi=0 div0=0", lo, hi, d0);
    else pass_cnt++;
  endtask

  task automatic test_div0;
    logic [63:0] hi, lo;
    logic        d0;
    run_op(1'b0, 1'b0, 64'h12345678, 64'd0, "div_by_zero", hi, lo, d0);
    total_cnt++;
    if (lo !== 64'hFFFFFFFF || hi !== 64'h12345678 || d0 !== 1'b1)
      $display("FAIL spec_div0: lo=%h hi=%h div0=%b, required lo=ffffffff hi=12345678 div0=1", lo, hi, d0);
    else pass_cnt++;
    // A later valid operation clears div0 again.
    run_op(1'b0, 1'b0, 64'd9, 64'd3, "after_div0", hi, lo, d0);
  endtask

  // A reset pulse in the middle of an operation, then a clean rerun.
  task automatic test_mid_reset;
    logic [63:0] hi, lo;
    logic        d0;
    drive(1'b0, 1'b1, 1'b0, 64'd100, 64'd7);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({hi32, lo32, busy32, done32, div0_32} !== 67'd0)
      $display("FAIL mid_reset_clear: hi=%h lo=%h busy=%b done=%b div0=%b, required all 0",
               hi32, lo32, busy32, done32, div0_32);
    else pass_cnt++;
    #2 reset_n = 1'b1;
    run_op(1'b0, 1'b0, 64'd100, 64'd7, "after_reset_100div7", hi, lo, d0);
    total_cnt++;
    if (lo !== 64'd14 || hi !== 64'd2)
      $display("FAIL spec_100div7: lo=%0d hi=%0d, required lo=14 hi=2", lo, hi);
    else pass_cnt++;
  endtask

  // 8-bit operation with start pulses during busy and the FINISH cycle.
  task automatic test_busy_starts;
    int dones, first_done;
    drive(1'b1, 1'b1, 1'b0, 64'hFF, 64'h10);
    @(posedge clk); #1;
    dones = 0;
    first_done = 0;
    for (int n = 1; n <= 9; n++) begin
      drive(1'b1, (n == 9) ? 1'b1 : 1'(bit'($urandom_range(1))), 1'(bit'($urandom_range(1))),
            {32'd0, $urandom}, {32'd0, $urandom});
      @(posedge clk); #1;
      if (done8 === 1'b1) begin
        dones++;
        if (first_done == 0) first_done = n;
      end
    end
    total_cnt++;
    if (first_done !== 9 || dones !== 1)
      $display("FAIL busy_starts_timing: first done at edge %0d (%0d pulses), required edge 9 (1 pulse)",
               first_done, dones);
    else pass_cnt++;
    total_cnt++;
    if (lo8 !== 8'h0F || hi8 !== 8'h0F || div0_8 !== 1'b0)
      $display("FAIL busy_starts_result: lo=%h hi=%h div0=%b, required lo=0f hi=0f div0=0", lo8, hi8, div0_8);
    else pass_cnt++;
    drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) dones++;
    end
    total_cnt++;
    if (dones !== 1 || busy8 !== 1'b0)
      $display("FAIL busy_starts_extra: %0d done/busy events total, busy=%b, required 1 and busy=0",
               dones, busy8);
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic [63:0] a, b, hi, lo;
    logic        d0, w8, sg;
    int          mode;
    for (int i = 0; i < 40; i++) begin
      w8   = 1'(i % 2);
      sg   = 1'(bit'($urandom_range(1)));
      mode = int'($urandom_range(7));
      a    = {$urandom, $urandom};
      if ($urandom_range(5) == 0) a = w8 ? 64'h80 : 64'h80000000;
      case (mode)
        0:       b = 64'd0;
        1:       b = 64'hFFFFFFFFFFFFFFFF;
        2:       b = 64'($urandom_range(15, 1));
        default: b = {$urandom, $urandom};
      endcase
      run_op(w8, sg, a, b, "random", hi, lo, d0);
    end
  endtask

  initial begin
    test_reset();
    test_signs();
    test_overflow();
    test_div0();
    test_mid_reset();
    test_busy_starts();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
